// File: rtl/apu_core_pkg.sv
// Shared types and constants for the audio playback unit: address/tone widths,
// FSM state encoding and the reference song image generator.
package apu_core_pkg;

  localparam int ADDR_W = 10;
  localparam int TONE_W = 4;
  localparam int WORD_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TONE_W-1:0] tone_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Reference song word i = {t3,t2,t1,t0} = {i+3, i+2, i+1, i}, each voice mod 16.
  function automatic logic [WORD_W-1:0] song_word(input int i);
    return {TONE_W'(i + 3), TONE_W'(i + 2), TONE_W'(i + 1), TONE_W'(i)};
  endfunction

endpackage

// File: rtl/apu_song_rom.sv
// Dual-read-port 1024x16 synchronous song ROM, one clock of read latency on both ports.
// Holds the reference song image; an empty SONG_FILE name yields a silent ROM.
module apu_song_rom
  import apu_core_pkg::*;
#(
  parameter string SONG_FILE = "song.mem"
) (
  input  logic              clk,
  input  addr_t             addr_a,
  input  addr_t             addr_b,
  output logic [WORD_W-1:0] q_a,
  output tone_t             q_b
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BLANK = (SONG_FILE == "");

  logic [WORD_W-1:0] image [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign image[i] = BLANK ? '0 : song_word(i);
  end

  // NOTE: ROM read registers carry no reset; consumers gate or re-latch them, and
  // leaving memory outputs unreset lets the array map onto block RAM.
  always_ff @(posedge clk) begin
    q_a <= image[addr_a];
    q_b <= image[addr_b][TONE_W-1:0];
  end

endmodule

// File: rtl/apu_core.sv
// Audio playback unit: steps through the song ROM from start_addr to end_addr once per
// note tick and pre-fetches the t0 voice lookahead_offset words ahead with a ready/ack handshake.
module apu_core
  import apu_core_pkg::*;
#(
  parameter logic [31:0] MAIN_CLK_SPEED = 32'd50_000_000,
  parameter logic [31:0] SLOW_CLK_SPEED = 32'd4,
  parameter string       SONG_FILE      = "song.mem"
) (
  input  logic  clk,
  input  logic  reset,
  input  addr_t start_addr,
  input  addr_t end_addr,
  input  logic  send_oneshot,
  input  addr_t lookahead_offset,
  input  logic  acknowledge_lookahead,
  output addr_t timestamp,
  output tone_t lookahead_tone,
  output logic  lookahead_ready,
  output logic  note_clk,
  output tone_t t0_me,
  output tone_t t1_me,
  output tone_t t2_me,
  output tone_t t3_me,
  output addr_t debug
);

  localparam logic [31:0] DIV_RAW = MAIN_CLK_SPEED / SLOW_CLK_SPEED;
  localparam logic [31:0] DIV     = (DIV_RAW < 32'd2) ? 32'd2 : DIV_RAW;
  localparam logic [31:0] HALF    = DIV / 32'd2;

  state_e            state;
  logic [31:0]       div_cnt;
  logic              tick;
  logic              os_sync, os_prev, os_edge;
  logic              launch;
  logic              play_vld;
  logic              la_pend, la_past;
  addr_t             ts_next, la_addr_next, la_remaining;
  logic [WORD_W-1:0] play_word;
  logic [WORD_W-1:0] tones;
  tone_t             la_word;

  assign tick    = (div_cnt == DIV - 32'd1);
  assign os_edge = os_sync & ~os_prev;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ts_next = timestamp;
    launch  = 1'b0;
    if (os_edge) begin
      ts_next = start_addr;
      launch  = 1'b1;
    end else if (state == PLAY && tick && timestamp != end_addr) begin
      ts_next = timestamp + ADDR_W'(1);
      launch  = 1'b1;
    end
  end

  // Lookahead address and song-end test use the timestamp being loaded this cycle.
  assign la_addr_next = ts_next + lookahead_offset;
  assign la_remaining = end_addr - ts_next;

  apu_song_rom #(
    .SONG_FILE(SONG_FILE)
  ) u_rom (
    .clk    (clk),
    .addr_a (timestamp),
    .addr_b (la_addr_next),
    .q_a    (play_word),
    .q_b    (la_word)
  );

  // The play port lags a timestamp change by one clock; play_vld hides the stale
  // word right after leaving IDLE, and the state term silences voices at song end.
  assign tones = (state == PLAY && play_vld) ? play_word : '0;
  assign {t3_me, t2_me, t1_me, t0_me} = tones;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      note_clk        <= 1'b0;
      os_sync         <= 1'b0;
      os_prev         <= 1'b0;
      timestamp       <= '0;
      play_vld        <= 1'b0;
      la_pend         <= 1'b0;
      la_past         <= 1'b0;
      debug           <= '0;
      lookahead_tone  <= '0;
      lookahead_ready <= 1'b0;
    end else begin
      os_sync  <= send_oneshot;
      os_prev  <= os_sync;
      note_clk <= (div_cnt < HALF);
      div_cnt  <= (os_edge || tick) ? '0 : div_cnt + 32'd1;

      timestamp <= ts_next;
      play_vld  <= (state == PLAY);

      if (os_edge) begin
        state <= PLAY;
      end else if (state == PLAY && tick && timestamp == end_addr) begin
        state <= IDLE;
      end

      la_pend <= launch;
      if (launch) begin
        debug   <= la_addr_next;
        la_past <= (la_remaining < lookahead_offset);
      end

      // Fresh data outranks a same-cycle acknowledge.
      if (la_pend) begin
        lookahead_tone  <= la_past ? '0 : la_word;
        lookahead_ready <= 1'b1;
      end else if (acknowledge_lookahead) begin
        lookahead_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_core.sv
// Directed bench for apu_core with DIV=2 and the reference song image
// ROM[i] = {i+3, i+2, i+1, i} (4-bit voices).
module tb_apu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] start_addr, end_addr, lookahead_offset;
  logic       send_oneshot, acknowledge_lookahead;
  logic [9:0] timestamp, debug;
  logic [3:0] lookahead_tone, t0_me, t1_me, t2_me, t3_me;
  logic       lookahead_ready, note_clk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_core #(
    .MAIN_CLK_SPEED(32'd40),
    .SLOW_CLK_SPEED(32'd20)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start_addr            (start_addr),
    .end_addr              (end_addr),
    .send_oneshot          (send_oneshot),
    .lookahead_offset      (lookahead_offset),
    .acknowledge_lookahead (acknowledge_lookahead),
    .timestamp             (timestamp),
    .lookahead_tone        (lookahead_tone),
    .lookahead_ready       (lookahead_ready),
    .note_clk              (note_clk),
    .t0_me                 (t0_me),
    .t1_me                 (t1_me),
    .t2_me                 (t2_me),
    .t3_me                 (t3_me),
    .debug                 (debug)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step falling edges until timestamp reaches exp or the budget runs out.
  task automatic wait_ts(input logic [9:0] exp, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timestamp !== exp && n < budget);
    check("ts_reach", 32'(timestamp), 32'(exp));
  endtask

  // Called on a falling edge; returns on the falling edge right after the load.
  task automatic pulse_oneshot();
    send_oneshot = 1'b1;
    repeat (2) @(negedge clk);
    send_oneshot = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ts"},    32'(timestamp), 32'd0);
    check({tag, "_tones"}, 32'({t3_me, t2_me, t1_me, t0_me}), 32'd0);
    check({tag, "_la"},    32'(lookahead_tone), 32'd0);
    check({tag, "_rdy"},   32'(lookahead_ready), 32'd0);
    check({tag, "_nclk"},  32'(note_clk), 32'd0);
    check({tag, "_dbg"},   32'(debug), 32'd0);
  endtask

  // Play one song from IDLE and check every word; ack_ts < 0 means no acknowledge.
  task automatic run_song(input logic [9:0] s, input logic [9:0] e_end,
                          input logic [9:0] off, input int ack_ts);
    logic [9:0] e, prev, rem, la;
    logic [3:0] exp_tone;
    bit         first, ack_active;
    int         n;
    start_addr       = s;
    end_addr         = e_end;
    lookahead_offset = off;
    pulse_oneshot();
    check("load_ts", 32'(timestamp), 32'(s));
    check("load_t0", 32'(t0_me), 32'd0);
    e          = s;
    first      = 1'b1;
    ack_active = 1'b0;
    forever begin
      if (!first) begin
        wait_ts(e, 4, n);
        check("step_gap", 32'(n), 32'd1);
        prev = e - 10'd1;
        check("t0_lag", 32'(t0_me), 32'(prev[3:0]));
        if (ack_active) check("ack_clear", 32'(lookahead_ready), 32'd0);
      end
      @(negedge clk);
      la       = e + off;
      rem      = e_end - e;
      exp_tone = (rem < off) ? 4'd0 : la[3:0];
      check("t0", 32'(t0_me), 32'(4'(e)));
      check("t1", 32'(t1_me), 32'(4'(e + 10'd1)));
      check("t2", 32'(t2_me), 32'(4'(e + 10'd2)));
      check("t3", 32'(t3_me), 32'(4'(e + 10'd3)));
      check("la_dbg",  32'(debug), 32'(la));
      check("la_tone", 32'(lookahead_tone), 32'(exp_tone));
      check("la_rdy",  32'(lookahead_ready), 32'd1);
      if (ack_active) begin
        acknowledge_lookahead = 1'b0;
        ack_active = 1'b0;
      end
      if (int'(e) == ack_ts) begin
        acknowledge_lookahead = 1'b1;
        ack_active = 1'b1;
      end
      if (e == e_end) break;
      e     = e + 10'd1;
      first = 1'b0;
    end
    @(negedge clk);
    check("end_ts",    32'(timestamp), 32'(e_end));
    check("end_tones", 32'({t3_me, t2_me, t1_me, t0_me}), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_ts",    32'(timestamp), 32'(e_end));
    check("idle_tones", 32'({t3_me, t2_me, t1_me, t0_me}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    start_addr            = '0;
    end_addr              = '0;
    lookahead_offset      = '0;
    send_oneshot          = 1'b0;
    acknowledge_lookahead = 1'b0;
    reset                 = 1'b1;
    #1 reset = 1'b0;
    #20 check_all_zero("rst");
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Plain song with a mid-song acknowledge at timestamp 5.
    run_song(10'd0, 10'd16, 10'd2, 5);

    // Wrap through 1023 -> 0.
    run_song(10'd1022, 10'd1, 10'd2, -1);

    // Restart during PLAY at timestamp 9, then a oneshot edge coinciding with a tick.
    start_addr       = 10'd3;
    end_addr         = 10'd16;
    lookahead_offset = 10'd2;
    pulse_oneshot();
    check("rs_load", 32'(timestamp), 32'd3);
    wait_ts(10'd9, 20, n);
    @(negedge clk);
    send_oneshot = 1'b1;
    wait_ts(10'd3, 6, n);
    check("restart_gap", 32'(n), 32'd2);
    send_oneshot = 1'b0;
    wait_ts(10'd4, 6, n);
    check("div_restart", 32'(n), 32'd2);
    send_oneshot = 1'b1;
    @(negedge clk);
    check("pre_tie", 32'(timestamp), 32'd4);
    @(negedge clk);
    check("tie_restart", 32'(timestamp), 32'd3);
    send_oneshot = 1'b0;

    // Asynchronous reset in the middle of playback.
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("nclk_toggle", 32'(note_clk), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("post_rst_ts",    32'(timestamp), 32'd0);
    check("post_rst_tones", 32'({t3_me, t2_me, t1_me, t0_me}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
